// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the sequencer-facing request handshake, the IMEM write port and the
// status outputs of instr_encoder.
//   master : sequencer side (drives start and the request, observes the rest)
//   slave  : encoder side
// Signals:
//   start                  clear pointer / wr_count / full / err
//   req_valid / req_ready  request handshake
//   fmt, funct3, funct7, rs1, rs2, rd, imm   instruction description
//   imem_we, imem_addr, imem_wdata           IMEM write port
//   wr_count, full, err, err_code            status
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        fmt;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   wr_count;
  logic              full;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, req_valid, fmt, funct3, funct7, rs1, rs2, rd, imm,
    input  req_ready, imem_we, imem_addr, imem_wdata, wr_count, full, err, err_code
  );

  modport slave (
    input  start, req_valid, fmt, funct3, funct7, rs1, rs2, rd, imm,
    output req_ready, imem_we, imem_addr, imem_wdata, wr_count, full, err, err_code
  );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs one instruction description per handshake into a 32-bit RISC-V word
// and writes it to instruction memory at an auto-incrementing word address.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   instr_encoder_if.slave (request handshake, IMEM write port, status)
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined   -> immediates that do not fit their field are rejected
//                (err_code 2, no write)
//   undefined -> immediates are silently truncated to the field bits
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_U = 7'b0110111;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_U = 3'd5;

  // wr_count value just before the final word is written
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_imem_we;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_range_ok;

  // Field packing; unused fields of a format are simply not referenced.
  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b1;
    case (bus.fmt)
      FMT_R:   w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
      FMT_I:   w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_I};
      FMT_S:   w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_S};
      FMT_B:   w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], OP_B};
      FMT_J:   w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                         bus.rd, OP_J};
      FMT_U:   w_word = {bus.imm[31:12], bus.rd, OP_U};
      default: w_legal = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // An immediate fits when every bit above the field's sign bit is a copy of
  // it; branch/jump offsets must additionally be even.
  always_comb begin
    w_range_ok = 1'b1;
    case (bus.fmt)
      FMT_I, FMT_S: w_range_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
      FMT_B:        w_range_ok = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
      FMT_J:        w_range_ok = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
      FMT_U:        w_range_ok = ~(|bus.imm[11:0]);
      default:      w_range_ok = 1'b1;
    endcase
  end
`else
  assign w_range_ok = 1'b1;
`endif

  // req_ready and imem_we are registered alongside the state so they are pure
  // functions of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_imem_we   <= 1'b0;
      r_word      <= 32'd0;
      r_ptr       <= '0;
      r_wr_count  <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ptr      <= '0;
            r_wr_count <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
          end else if (bus.req_valid) begin
            if (!w_legal) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd1;
            end else if (!w_range_ok) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd2;
            end else begin
              r_word      <= w_word;
              r_state     <= S_WRITE;
              r_req_ready <= 1'b0;
              r_imem_we   <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          r_imem_we <= 1'b0;
          if (bus.start) begin
            // The write of this cycle still lands; counters restart afterwards.
            r_ptr       <= '0;
            r_wr_count  <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_wr_count <= r_wr_count + 1'b1;
            if (r_wr_count == LAST_CNT) begin
              // Pointer holds at the last address rather than wrapping.
              r_state     <= S_FULL;
              r_req_ready <= 1'b0;
            end else begin
              r_ptr       <= r_ptr + 1'b1;
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end
          end
        end

        S_FULL: begin
          if (bus.start) begin
            r_ptr       <= '0;
            r_wr_count  <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else if (bus.req_valid) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd3;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_imem_we   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_ptr;
  assign bus.imem_wdata = r_word;
  assign bus.wr_count   = r_wr_count;
  // wr_count never exceeds 2^ADDR_W, so its MSB alone marks the full condition
  assign bus.full       = r_wr_count[ADDR_W];
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader: the inverse of the decode stage. It accepts one instruction description per handshake (format, funct fields, register indices, immediate), packs it into a 32-bit RISC-V word using the standard field layout, and writes it into instruction memory at an auto-incrementing word address. It sits between a test or boot sequencer and the IMEM write port, so programs can be built at runtime without a hex file.

## Interface
- ADDR_W, 8, IMEM word-address width; capacity is 2^ADDR_W words.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  clears the write pointer, `wr_count`, `full` and `err`.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- fmt  in  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=J, 5=U; 6 and 7 are illegal.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- rs1, rs2, rd  in  5 each  register indices.
- imm  in  32  immediate: signed value for I/S, signed byte offset for B/J, full upper value for U.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  encoded word.
- wr_count  out  ADDR_W+1  number of words written since reset or `start`.
- full  out  1  `wr_count == 2^ADDR_W`.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0=none, 1=illegal fmt, 2=immediate out of range, 3=request while full. Holds the last error.

## Operation
- Opcodes come from `Definition_List.v`:
  - R 0110011, I 0010011, S 0100011, B 1100011, J 1101111, U 0110111.
- Encodings, MSB first:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - U: {imm[31:12], rd, op}.
- Fields a format does not use are ignored.
- FSM states: IDLE, WRITE, FULL.
  - IDLE:
    - `req_ready = 1`.
    - On handshake with a legal request: register the encoded word, go to WRITE.
    - On handshake with an illegal fmt: set `err`, `err_code = 1`, no write, stay in IDLE.
  - WRITE:
    - `req_ready = 0`, `imem_we = 1`, `imem_addr` = pointer, `imem_wdata` = registered word.
    - Next state: pointer++ and `wr_count`++.
    - Go to FULL if `wr_count` reaches 2^ADDR_W, otherwise IDLE.
  - FULL:
    - `req_ready = 0`.
    - A `req_valid` high cycle sets `err`, `err_code = 3` (request dropped).
- `start`:
  - Sampled every cycle.
  - In IDLE or FULL: pointer = 0, `wr_count = 0`, `err = 0`, `err_code = 0`, next state IDLE.
  - In WRITE: the write still occurs at the current pointer, then pointer and `wr_count` go to 0 rather than incrementing.
  - `start` takes priority over a simultaneous handshake; the request is not accepted.
- The pointer is ADDR_W wide and never wraps; FULL blocks further writes.

## Timing
- Reset values:
  - `imem_we = 0`, `imem_addr = 0`, `imem_wdata = 0`, `wr_count = 0`, `full = 0`, `err = 0`, `err_code = 0`.
  - State IDLE, so `req_ready = 1`.
- Latency: handshake in cycle N, `imem_we` high in N+1, `req_ready` high again in N+2 (or the design is in FULL).
- Peak throughput is one word per 2 cycles.
- `req_ready` and `imem_we` decode from state only; `req_ready` does not depend on `req_valid`.
- `imem_we` is high for exactly one cycle per accepted legal request.
- `rst` asserted mid-WRITE forces `imem_we` low immediately (asynchronous) and returns all state to reset values.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: an accepted request fails the range check if any of the following hold:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] ≠ 0.
- On failure: `err` set, `err_code = 2`, no write, stay in IDLE.
- `ENC_RANGE_CHECK_EN` undefined: the immediate is silently truncated to the field bits; `err_code = 2` is never produced.

## Test plan
- R add x3,x1,x2 (fmt 0, funct7 0, funct3 0, rs1 1, rs2 2, rd 3) -> `imem_we` one cycle after handshake, `imem_addr = 0`, `imem_wdata = 0x002081B3`, `wr_count = 1`.
- Back-to-back:
  - I addi x5,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00293 at addr 0.
  - B beq x1,x2,+8 -> 0x00208463 at addr 1.
  - J jal x1,+2048 -> 0x001000EF at addr 2.
  - U lui x7,0x12345000 -> 0x123453B7 at addr 3.
  - `req_ready` low on each WRITE cycle.
- fmt = 6 -> no `imem_we`, `err = 1`, `err_code = 1`, pointer unchanged. Then I with imm 4096:
  - With `ENC_RANGE_CHECK_EN`: `err_code = 2`, no write.
  - Without it: writes 0x00000293-style word with imm field 0.
- ADDR_W = 2: four writes -> `full = 1`, `wr_count = 4`, `req_ready = 0`. Fifth `req_valid` -> `err_code = 3`. Then `start` -> `wr_count = 0`, `full = 0`, next write at addr 0.
- `start` asserted during WRITE -> that write lands at the current address, and the following accepted request writes addr 0.
- `rst` pulse during WRITE -> `imem_we` drops in the same cycle, all outputs return to reset values, `req_ready = 1` after release.
